// File: rtl/piso_top.sv
// ============================================================================
// Module   : piso_top
// Brief    : Parallel-in / serial-out shift register, LSB shifted out first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module piso_top #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] q,
  output logic             so
);

  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shift_q;

  // Load has priority; otherwise shift right with zero fill, so no recirculation.
  always_comb begin
    shift_d = shift_q >> 1;
    if (load) begin
      shift_d = pi;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q  = shift_q;
  assign so = shift_q[0];

endmodule

`default_nettype wire

// File: tb/tb_piso_top.sv
// ============================================================================
// Module   : tb_piso_top
// Brief    : Directed and randomized self-checking bench for piso_top.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_piso_top;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] pi;
  logic [3:0] q;
  logic       so;

  int checks;
  int errors;

  piso_top #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .pi    (pi),
    .q     (q),
    .so    (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs, then compare q and so against exp.
  task automatic step(input string tag, input logic ld, input logic [3:0] p, input int exp);
    logic [3:0] eq;
    logic [3:0] es;
    load = ld;
    pi   = p;
    @(posedge clk);
    #1;
    eq = exp[3:0];
    es = 4'(exp % 2);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_so"}, {3'b000, so}, es);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_q"}, q, 4'b0000);
    chk({tag, "_so"}, {3'b000, so}, 4'b0000);
    #1;
    reset = 1'b0;
  endtask

  int m;
  int m_next;
  logic       ld;
  logic [3:0] p;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    load   = 1'b0;
    pi     = 4'b0000;

    // Reset asserted from time zero: outputs must clear before any edge.
    #1;
    chk("rst_pre_edge_q", q, 4'b0000);
    chk("rst_pre_edge_so", {3'b000, so}, 4'b0000);
    @(posedge clk);
    #1;
    chk("rst_edge_q", q, 4'b0000);
    // Load during reset is ignored.
    load = 1'b1;
    pi   = 4'b1111;
    @(posedge clk);
    #1;
    chk("rst_ignore_load_q", q, 4'b0000);
    chk("rst_ignore_load_so", {3'b000, so}, 4'b0000);
    load  = 1'b0;
    pi    = 4'b0000;
    reset = 1'b0;

    step("idle_after_rst", 1'b0, 4'b0000, 0);

    // Load 1011 then drain: so = 1,1,0,1 then zeros.
    step("ld1011",   1'b1, 4'b1011, 11);
    step("sh1011_1", 1'b0, 4'b0000, 5);
    step("sh1011_2", 1'b0, 4'b0000, 2);
    step("sh1011_3", 1'b0, 4'b0000, 1);
    step("sh1011_4", 1'b0, 4'b0000, 0);
    for (int i = 0; i < 4; i++) step("sh1011_idle", 1'b0, 4'b1111, 0);

    // Load 1100: so = 0,0,1,1,0.
    step("ld1100",   1'b1, 4'b1100, 12);
    step("sh1100_1", 1'b0, 4'b0000, 6);
    step("sh1100_2", 1'b0, 4'b0000, 3);
    step("sh1100_3", 1'b0, 4'b0000, 1);
    step("sh1100_4", 1'b0, 4'b0000, 0);

    // Mid-shift reload discards remaining bits.
    step("mid_ld1011", 1'b1, 4'b1011, 11);
    step("mid_sh1",    1'b0, 4'b0000, 5);
    step("mid_sh2",    1'b0, 4'b0000, 2);
    step("mid_ld0110", 1'b1, 4'b0110, 6);
    step("mid_sh3",    1'b0, 4'b0000, 3);

    // Async reset between edges aborts the shift.
    step("ar_ld1111", 1'b1, 4'b1111, 15);
    step("ar_sh1",    1'b0, 4'b0000, 7);
    reset_pulse("ar_pulse");
    step("ar_after1", 1'b0, 4'b0000, 0);
    step("ar_after2", 1'b0, 4'b0000, 0);

    // Back-to-back loads.
    step("b2b_0001", 1'b1, 4'b0001, 1);
    step("b2b_1000", 1'b1, 4'b1000, 8);
    step("b2b_1010", 1'b1, 4'b1010, 10);
    step("b2b_sh",   1'b0, 4'b0000, 5);

    // Randomized run against an arithmetic reference: load -> value, else halve.
    m = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset_pulse("rnd_rst");
        m = 0;
      end
      ld = ($urandom_range(0, 2) == 0);
      p  = 4'($urandom_range(0, 15));
      m_next = ld ? int'(p) : m / 2;
      step("rnd", ld, p, m_next);
      m = m_next;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piso_top.md
PISO_TOP -- requirements
Module: piso_top

Interface
REQ-001 Parameter: WIDTH, default 4, register and parallel-input width; all requirements below are stated for WIDTH=4.
REQ-002 clk  input  1  single clock; all state changes on rising edge except reset.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  synchronous parallel-load enable, active-high.
REQ-005 pi  input  4  parallel data input, sampled only when load=1.
REQ-006 q  output  4  current shift-register contents, registered.
REQ-007 so  output  1  serial output; SHALL equal q[0] combinationally at all times.

Function
REQ-008 The block SHALL be a 4-bit parallel-in/serial-out (PISO) shift register built from one D-type storage stage per bit.
REQ-009 Rising edge, reset=0, load=1: q SHALL take pi in the same edge; 1-cycle latency from load to q/so.
REQ-010 Rising edge, reset=0, load=0: q SHALL shift right by one, q[3] <- 0, q[2:0] <- q[3:1], so LSB leaves first.
REQ-011 After a load, so SHALL present pi[0], pi[1], pi[2], pi[3] on four successive cycles, then 0.
REQ-012 Once all bits have shifted out, q SHALL stay 4'b0000 while load=0; no wrap-around or recirculation.
REQ-013 load=1 on consecutive edges SHALL reload pi each edge with no shift in between.
REQ-014 load asserted mid-shift SHALL discard the remaining bits and load pi in full on that edge.
REQ-015 Holding q constant SHALL be impossible without load=1; the block has no hold/enable state.
REQ-016 No handshake, no busy flag, no internal FSM beyond the 4 data bits.
REQ-017 Outputs SHALL be glitch-free between edges apart from the combinational so=q[0] path.

Reset
REQ-018 reset=1 SHALL force q=4'b0000 and so=0 immediately, with no clock edge required.
REQ-019 While reset=1, load and pi SHALL be ignored on every clock edge.
REQ-020 Reset asserted mid-shift SHALL abort the shift; after release, q stays 0 until the next load.
REQ-021 On release of reset, the first rising edge SHALL act normally, per REQ-009/REQ-010.

Verification
REQ-022 Reset: assert reset 10 ns with load=0, pi=0 -> q=0000, so=0 before any edge and throughout.
REQ-023 Load/shift: load=1, pi=1011 for 1 edge, then load=0 for 8 edges -> q=1011, 0101, 0010, 0001, 0000, 0000...; so sequence 1, 1, 0, 1, 0, 0...
REQ-024 Second load: load=1, pi=1100 for 1 edge, then load=0 -> q=1100, 0110, 0011, 0001, 0000; so sequence 0, 0, 1, 1, 0.
REQ-025 Mid-shift reload: load 1011, shift 2 edges (q=0010), then load=1, pi=0110 -> q=0110 on that edge, so=0.
REQ-026 Async reset mid-shift: load 1111, shift 1 edge (q=0111), pulse reset between edges -> q=0000 and so=0 instantly; q stays 0000 after release with load=0.
REQ-027 Back-to-back loads: load=1 for 3 edges with pi=0001, 1000, 1010 -> q follows pi each edge, so=1, 0, 0.
